// File: rtl/seg_instruction_fetch.sv
// MIPS IF stage: program counter, debug-loaded instruction memory and IF/ID register.
// Applies branch/jump/stall/flush redirects and latches the HALT word.
module seg_instruction_fetch #(
  parameter int               LEN          = 32,
  parameter int               NB_IMEM_ADDR = 10,
  parameter logic [LEN-1:0]   HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_jump_flag,
  input  logic [LEN-1:0]          i_PC_jump,
  input  logic                    i_PCSrc,
  input  logic [LEN-1:0]          i_PC_branch,
  input  logic                    i_flush,
  input  logic                    i_wr_en,
  input  logic [NB_IMEM_ADDR-1:0] i_wr_addr,
  input  logic [LEN-1:0]          i_wr_data,
  output logic [LEN-1:0]          o_PC,
  output logic [LEN-1:0]          o_instruction,
  output logic [LEN-1:0]          o_pc_current,
  output logic                    o_halt
);

  localparam int DEPTH = 1 << NB_IMEM_ADDR;
  localparam logic [LEN-1:0] ZERO_WORD = {LEN{1'b0}};
  localparam logic [LEN-1:0] ONE_WORD  = {{(LEN-1){1'b0}}, 1'b1};

  logic [LEN-1:0] imem_q [DEPTH];

  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] pc_out_q, pc_out_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic           halt_q, halt_d;

  logic [LEN-1:0] fetch_word_s;
  logic [LEN-1:0] pc_inc_s;

  assign fetch_word_s = imem_q[pc_q[NB_IMEM_ADDR-1:0]];
  assign pc_inc_s     = pc_q + ONE_WORD;

  // Instruction memory write port; never reset and independent of enable/stall/halt.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      imem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Next-state selection for PC, IF/ID and halt latch, in redirect priority order.
  always_comb begin
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    halt_d   = halt_q;
    if (i_enable) begin
      if (i_PCSrc) begin
        pc_d     = i_PC_branch;
        pc_out_d = ZERO_WORD;
        instr_d  = ZERO_WORD;
        halt_d   = 1'b0;
      end else if (i_stall) begin
        // ID re-presents its instruction, so a jump seen now is taken on release.
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
      end else if (i_jump_flag) begin
        pc_d     = i_PC_jump;
        pc_out_d = ZERO_WORD;
        instr_d  = ZERO_WORD;
      end else if (i_flush) begin
        pc_d     = pc_inc_s;
        pc_out_d = ZERO_WORD;
        instr_d  = ZERO_WORD;
      end else if (halt_q) begin
        pc_d     = pc_q;
        pc_out_d = ZERO_WORD;
        instr_d  = ZERO_WORD;
      end else begin
        pc_out_d = pc_inc_s;
        instr_d  = fetch_word_s;
        if (fetch_word_s == HALT_WORD) begin
          halt_d = 1'b1;
          pc_d   = pc_q;
        end else begin
          pc_d   = pc_inc_s;
        end
      end
    end else begin
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      halt_d   = halt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pc_q     <= ZERO_WORD;
      pc_out_q <= ZERO_WORD;
      instr_q  <= ZERO_WORD;
      halt_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      halt_q   <= halt_d;
    end
  end

  assign o_PC          = pc_out_q;
  assign o_instruction = instr_q;
  assign o_pc_current  = pc_q;
  assign o_halt        = halt_q;

endmodule
